// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, fetches over a req/ready handshake, and handles stall and redirect.
module if_stage #(
  parameter int                      WORDLENGTH = 32,
  parameter logic [WORDLENGTH-1:0]   RESET_PC   = '0,
  parameter logic [WORDLENGTH-1:0]   NOP        = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [1:0]            Branch_taken,
  input  logic                  IF_Flush,
  input  logic [WORDLENGTH-1:0] branch_address,
  input  logic [WORDLENGTH-1:0] jump_address,
  output logic                  imem_req,
  output logic [WORDLENGTH-1:0] imem_addr,
  input  logic [WORDLENGTH-1:0] imem_rdata,
  input  logic                  imem_ready,
  output logic [WORDLENGTH-1:0] IF_ID_PC,
  output logic [WORDLENGTH-1:0] instruction,
  output logic                  IF_ID_valid
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WORDLENGTH-1:0] pc_q, pc_d;
  logic [WORDLENGTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [WORDLENGTH-1:0] buf_q, buf_d;
  logic [WORDLENGTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [WORDLENGTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;

  logic                  redirect;
  logic [WORDLENGTH-1:0] target;
  logic [WORDLENGTH-1:0] pc_plus4;

  // A stalled redirect is ignored so the branch stays in ID until the stall clears.
  assign redirect = IF_Flush && (Branch_taken != 2'b00) && !stall;
  assign target   = (Branch_taken == 2'b01) ? branch_address : jump_address;
  assign pc_plus4 = pc_q + WORDLENGTH'(4);

  assign imem_req    = reset && (state_q != HOLD);
  assign imem_addr   = pc_q;
  assign IF_ID_PC    = ifid_pc_q;
  assign instruction = instr_q;
  assign IF_ID_valid = valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_d         = buf_q;
    ifid_pc_d     = ifid_pc_q;
    instr_d       = instr_q;
    valid_d       = valid_q;

    case (state_q)
      FETCH: begin
        if (redirect) begin
          instr_d = NOP;
          valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            // pc stays put so the outstanding address remains stable.
            redirect_pc_d = target;
            state_d       = DRAIN;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            ifid_pc_d = pc_plus4;
            instr_d   = imem_rdata;
            valid_d   = 1'b1;
            pc_d      = pc_plus4;
          end else begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end else if (!stall) begin
          instr_d = NOP;
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = NOP;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          ifid_pc_d = pc_plus4;
          instr_d   = buf_q;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          state_d   = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          redirect_pc_d = target;
        end
        if (!stall) begin
          instr_d = NOP;
          valid_d = 1'b0;
        end
        // The late response belongs to the wrong path and is dropped.
        if (imem_ready) begin
          pc_d    = redirect ? target : redirect_pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= '0;
      buf_q         <= '0;
      ifid_pc_q     <= '0;
      instr_q       <= NOP;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      buf_q         <= buf_d;
      ifid_pc_q     <= ifid_pc_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard-driven bench for if_stage: each queued cycle carries its stimulus
// and the expected fetch request and IF/ID contents.
module tb_if_stage;

  typedef struct {
    string       nm;
    logic        rdy;
    logic        st;
    logic [1:0]  bt;
    logic        fl;
    logic [31:0] br;
    logic [31:0] jp;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic        v;
  } cyc_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  Branch_taken;
  logic        IF_Flush;
  logic [31:0] branch_address;
  logic [31:0] jump_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IF_ID_PC;
  logic [31:0] instruction;
  logic        IF_ID_valid;

  cyc_t sb[$];
  int   total  = 0;
  int   passed = 0;

  if_stage #(
    .WORDLENGTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP       (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .Branch_taken  (Branch_taken),
    .IF_Flush      (IF_Flush),
    .branch_address(branch_address),
    .jump_address  (jump_address),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .IF_ID_PC      (IF_ID_PC),
    .instruction   (instruction),
    .IF_ID_valid   (IF_ID_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory returns a word tagged with its own address.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic void expect_cycle(input string nm, input logic rdy, input logic st,
                                       input logic [1:0] bt, input logic fl,
                                       input logic [31:0] br, input logic [31:0] jp,
                                       input logic req, input logic [31:0] addr,
                                       input logic [31:0] ipc, input logic [31:0] ins,
                                       input logic v);
    cyc_t c;
    c.nm = nm; c.rdy = rdy; c.st = st; c.bt = bt; c.fl = fl; c.br = br; c.jp = jp;
    c.req = req; c.addr = addr; c.ipc = ipc; c.ins = ins; c.v = v;
    sb.push_back(c);
  endfunction

  task automatic applyStimulus(input cyc_t c);
    @(negedge clk);
    imem_ready     = c.rdy;
    stall          = c.st;
    Branch_taken   = c.bt;
    IF_Flush       = c.fl;
    branch_address = c.br;
    jump_address   = c.jp;
  endtask

  task automatic test_reset;
    reset = 1'b0; stall = 1'b0; Branch_taken = 2'b00; IF_Flush = 1'b0;
    branch_address = '0; jump_address = '0; imem_ready = 1'b0;
    #2;
    total++;
    if ({imem_req, imem_addr, IF_ID_PC, instruction, IF_ID_valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("[TB] FAIL reset_state: got req=%b addr=%h pc=%h ins=%h v=%b, want 0/0/0/0/0",
               imem_req, imem_addr, IF_ID_PC, instruction, IF_ID_valid);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sequential;
    cyc_t c;
    for (int i = 0; i < 2; i++)
      expect_cycle($sformatf("seq%0d", i), 1, 0, 2'b00, 0, 0, 0, 1, 32'(4*i), 32'(4*i+4), word(32'(4*i)), 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      applyStimulus(c);
      #1;
      total++;
      if (imem_req !== c.req || (c.req && imem_addr !== c.addr))
        $display("[TB] FAIL %s_fetch: got req=%b addr=%h, want req=%b addr=%h", c.nm, imem_req, imem_addr, c.req, c.addr);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({IF_ID_PC, instruction, IF_ID_valid} !== {c.ipc, c.ins, c.v})
        $display("[TB] FAIL %s_ifid: got pc=%h ins=%h v=%b, want pc=%h ins=%h v=%b", c.nm, IF_ID_PC, instruction, IF_ID_valid, c.ipc, c.ins, c.v);
      else passed++;
    end
  endtask

  task automatic test_stall;
    cyc_t c;
    expect_cycle("stall1", 1, 1, 2'b00, 0, 0, 0, 1, 32'h8, 32'h8, word(32'h4), 1);
    expect_cycle("stall2", 1, 1, 2'b00, 0, 0, 0, 0, 32'h8, 32'h8, word(32'h4), 1);
    expect_cycle("stall3", 1, 1, 2'b00, 0, 0, 0, 0, 32'h8, 32'h8, word(32'h4), 1);
    expect_cycle("unstall", 1, 0, 2'b00, 0, 0, 0, 0, 32'h8, 32'hC, word(32'h8), 1);
    expect_cycle("postst", 1, 0, 2'b00, 0, 0, 0, 1, 32'hC, 32'h10, word(32'hC), 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      applyStimulus(c);
      #1;
      total++;
      if (imem_req !== c.req || (c.req && imem_addr !== c.addr))
        $display("[TB] FAIL %s_fetch: got req=%b addr=%h, want req=%b addr=%h", c.nm, imem_req, imem_addr, c.req, c.addr);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({IF_ID_PC, instruction, IF_ID_valid} !== {c.ipc, c.ins, c.v})
        $display("[TB] FAIL %s_ifid: got pc=%h ins=%h v=%b, want pc=%h ins=%h v=%b", c.nm, IF_ID_PC, instruction, IF_ID_valid, c.ipc, c.ins, c.v);
      else passed++;
    end
  endtask

  task automatic test_redirect;
    cyc_t c;
    expect_cycle("br_take", 1, 0, 2'b01, 1, 32'h40, 0, 1, 32'h10, 32'h10, 32'h0, 0);
    expect_cycle("br_tgt", 1, 0, 2'b00, 0, 0, 0, 1, 32'h40, 32'h44, word(32'h40), 1);
    expect_cycle("dr_enter", 0, 0, 2'b10, 1, 0, 32'h100, 1, 32'h44, 32'h44, 32'h0, 0);
    expect_cycle("dr_wait", 0, 0, 2'b00, 0, 0, 0, 1, 32'h44, 32'h44, 32'h0, 0);
    expect_cycle("dr_drop", 1, 0, 2'b00, 0, 0, 0, 1, 32'h44, 32'h44, 32'h0, 0);
    expect_cycle("dr_tgt", 1, 0, 2'b00, 0, 0, 0, 1, 32'h100, 32'h104, word(32'h100), 1);
    expect_cycle("re_first", 0, 0, 2'b01, 1, 32'h300, 0, 1, 32'h104, 32'h104, 32'h0, 0);
    expect_cycle("re_later", 0, 0, 2'b11, 1, 0, 32'h500, 1, 32'h104, 32'h104, 32'h0, 0);
    expect_cycle("re_drop", 1, 0, 2'b00, 0, 0, 0, 1, 32'h104, 32'h104, 32'h0, 0);
    expect_cycle("re_tgt", 1, 0, 2'b00, 0, 0, 0, 1, 32'h500, 32'h504, word(32'h500), 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      applyStimulus(c);
      #1;
      total++;
      if (imem_req !== c.req || (c.req && imem_addr !== c.addr))
        $display("[TB] FAIL %s_fetch: got req=%b addr=%h, want req=%b addr=%h", c.nm, imem_req, imem_addr, c.req, c.addr);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({IF_ID_PC, instruction, IF_ID_valid} !== {c.ipc, c.ins, c.v})
        $display("[TB] FAIL %s_ifid: got pc=%h ins=%h v=%b, want pc=%h ins=%h v=%b", c.nm, IF_ID_PC, instruction, IF_ID_valid, c.ipc, c.ins, c.v);
      else passed++;
    end
  endtask

  task automatic test_stalled_redirect;
    cyc_t c;
    expect_cycle("sr_wait", 0, 1, 2'b10, 1, 0, 32'h900, 1, 32'h504, 32'h504, word(32'h500), 1);
    expect_cycle("sr_buf", 1, 1, 2'b10, 1, 0, 32'h900, 1, 32'h504, 32'h504, word(32'h500), 1);
    expect_cycle("sr_hold", 1, 1, 2'b10, 1, 0, 32'h900, 0, 32'h504, 32'h504, word(32'h500), 1);
    expect_cycle("sr_rel", 1, 0, 2'b00, 0, 0, 0, 0, 32'h504, 32'h508, word(32'h504), 1);
    expect_cycle("sr_next", 1, 0, 2'b00, 0, 0, 0, 1, 32'h508, 32'h50C, word(32'h508), 1);
    expect_cycle("nr_bub", 0, 0, 2'b00, 0, 0, 0, 1, 32'h50C, 32'h50C, 32'h0, 0);
    expect_cycle("nr_ok", 1, 0, 2'b00, 0, 0, 0, 1, 32'h50C, 32'h510, word(32'h50C), 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      applyStimulus(c);
      #1;
      total++;
      if (imem_req !== c.req || (c.req && imem_addr !== c.addr))
        $display("[TB] FAIL %s_fetch: got req=%b addr=%h, want req=%b addr=%h", c.nm, imem_req, imem_addr, c.req, c.addr);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({IF_ID_PC, instruction, IF_ID_valid} !== {c.ipc, c.ins, c.v})
        $display("[TB] FAIL %s_ifid: got pc=%h ins=%h v=%b, want pc=%h ins=%h v=%b", c.nm, IF_ID_PC, instruction, IF_ID_valid, c.ipc, c.ins, c.v);
      else passed++;
    end
  endtask

  task automatic test_wrap_and_hold_redirect;
    cyc_t c;
    expect_cycle("wr_jump", 1, 0, 2'b10, 1, 0, 32'hFFFF_FFFC, 1, 32'h510, 32'h510, 32'h0, 0);
    expect_cycle("wr_top", 1, 0, 2'b00, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, word(32'hFFFF_FFFC), 1);
    expect_cycle("wr_zero", 1, 0, 2'b00, 0, 0, 0, 1, 32'h0, 32'h4, word(32'h0), 1);
    expect_cycle("hr_buf", 1, 1, 2'b00, 0, 0, 0, 1, 32'h4, 32'h4, word(32'h0), 1);
    expect_cycle("hr_redir", 1, 0, 2'b01, 1, 32'h80, 0, 0, 32'h4, 32'h4, 32'h0, 0);
    expect_cycle("hr_tgt", 1, 0, 2'b00, 0, 0, 0, 1, 32'h80, 32'h84, word(32'h80), 1);
    expect_cycle("rd_enter", 0, 0, 2'b10, 1, 0, 32'hC00, 1, 32'h84, 32'h84, 32'h0, 0);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      applyStimulus(c);
      #1;
      total++;
      if (imem_req !== c.req || (c.req && imem_addr !== c.addr))
        $display("[TB] FAIL %s_fetch: got req=%b addr=%h, want req=%b addr=%h", c.nm, imem_req, imem_addr, c.req, c.addr);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({IF_ID_PC, instruction, IF_ID_valid} !== {c.ipc, c.ins, c.v})
        $display("[TB] FAIL %s_ifid: got pc=%h ins=%h v=%b, want pc=%h ins=%h v=%b", c.nm, IF_ID_PC, instruction, IF_ID_valid, c.ipc, c.ins, c.v);
      else passed++;
    end
  endtask

  // Entered with the DUT sitting in DRAIN toward 0xC00.
  task automatic test_reset_mid_drain;
    cyc_t c;
    @(negedge clk);
    Branch_taken = 2'b00; IF_Flush = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr, IF_ID_PC, instruction, IF_ID_valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("[TB] FAIL async_reset: got req=%b addr=%h pc=%h ins=%h v=%b, want 0/0/0/0/0",
               imem_req, imem_addr, IF_ID_PC, instruction, IF_ID_valid);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    expect_cycle("rs_idle", 0, 0, 2'b00, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0);
    expect_cycle("rs_fetch", 1, 0, 2'b00, 0, 0, 0, 1, 32'h0, 32'h4, word(32'h0), 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      applyStimulus(c);
      #1;
      total++;
      if (imem_req !== c.req || (c.req && imem_addr !== c.addr))
        $display("[TB] FAIL %s_fetch: got req=%b addr=%h, want req=%b addr=%h", c.nm, imem_req, imem_addr, c.req, c.addr);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({IF_ID_PC, instruction, IF_ID_valid} !== {c.ipc, c.ins, c.v})
        $display("[TB] FAIL %s_ifid: got pc=%h ins=%h v=%b, want pc=%h ins=%h v=%b", c.nm, IF_ID_PC, instruction, IF_ID_valid, c.ipc, c.ins, c.v);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stalled_redirect();
    test_wrap_and_hold_redirect();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
